// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// Holds FSM state encoding and operation mode codes.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_bit_cell.sv
// One-bit full adder / full subtractor cell (combinational).
// Ports: x, y operand bits; cin carry/borrow in; mode 0=add 1=sub; s sum/diff; cout carry/borrow out.
module serial_bit_cell
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p = x ^ y;
  assign s   = w_p ^ cin;

  always_comb begin
    cout = 1'b0;
    if (mode == MODE_SUB)
      cout = (~x & y) | (cin & ~w_p);
    else
      cout = (x & y) | (cin & w_p);
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/sub: loads W-bit operands on start, processes LSB-first, one bit per clock.
// Ports: clk, rst (sync, high); start/mode/a/b in; ready/busy/done status; result/carry_out/overflow held.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a_sh;
  logic [W-1:0]       r_b_sh;
  logic [W-1:0]       r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode;
  logic               r_cy;
  logic               r_cy_msb;
  logic [W-1:0]       r_result;
  logic               r_carry;
  logic               r_ovf;
  logic               w_s;
  logic               w_cout;
  logic               w_last;

  serial_bit_cell u_cell (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .cin  (r_cy),
    .mode (r_mode),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_last = (r_cnt == CNT_W'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_mode   <= MODE_ADD;
      r_cy     <= 1'b0;
      r_cy_msb <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_mode <= mode;
            r_cy   <= 1'b0;
            r_cnt  <= '0;
            r_sh   <= '0;
          end
        end
        ST_SHIFT: begin
          r_sh   <= {w_s, r_sh[W-1:1]};
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
          r_cy   <= w_cout;
          // r_cy here is the carry/borrow entering the MSB
          if (w_last) r_cy_msb <= r_cy;
        end
        ST_DONE: begin
          r_result <= r_sh;
          r_carry  <= r_cy;
          r_ovf    <= r_cy_msb ^ r_cy;
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (W=8).
// Behavioural model tracks op timing and arithmetic; directed literals pin the model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_add_sub #(.W(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1..W shifting, W+1 done cycle
  int           m_phase = 0;
  logic [W-1:0] m_a, m_b;
  logic         m_mode;
  logic [W-1:0] m_res = '0;
  logic         m_cy  = 1'b0;
  logic         m_ov  = 1'b0;

  function automatic void compute(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic md, output logic [W-1:0] r,
                                  output logic c, output logic v);
    int unsigned sum;
    if (md == 1'b0) begin
      sum = int'(x) + int'(y);
      r   = W'(sum);
      c   = (sum >= (1 << W));
      v   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x < y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
      m_cy    = 1'b0;
      m_ov    = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     = a;
        m_b     = b;
        m_mode  = mode;
        m_phase = 1;
      end
    end else if (m_phase == W + 1) begin
      compute(m_a, m_b, m_mode, m_res, m_cy, m_ov);
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", W'(ready), W'(m_phase == 0));
      chk("m_busy", W'(busy), W'(m_phase >= 1 && m_phase <= W));
      chk("m_done", W'(done), W'(m_phase == W + 1));
      chk("m_result", result, m_res);
      chk("m_carry", W'(carry_out), W'(m_cy));
      chk("m_ovf", W'(overflow), W'(m_ov));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: no done within 20 cycles at %0t", $time);
  endtask

  task automatic op(input logic md, input logic [W-1:0] x,
                    input logic [W-1:0] y, output int lat);
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    lat = lat + 1;
    @(negedge clk);
    chk("done_one_cycle", W'(done), W'(0));
  endtask

  task automatic lit(input string nm, input logic [W-1:0] r,
                     input logic c, input logic v);
    chk({nm, "_res"}, result, r);
    chk({nm, "_cy"}, W'(carry_out), W'(c));
    chk({nm, "_ov"}, W'(overflow), W'(v));
  endtask

  initial begin
    int lat;
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    lit("rst", 8'h00, 1'b0, 1'b0);

    op(1'b0, 8'h7F, 8'h01, lat);
    chk("latency", W'(lat), W'(9));
    lit("add7f", 8'h80, 1'b0, 1'b1);
    op(1'b0, 8'hFF, 8'h01, lat);
    lit("addff", 8'h00, 1'b1, 1'b0);
    op(1'b1, 8'h05, 8'h03, lat);
    lit("sub53", 8'h02, 1'b0, 1'b0);
    op(1'b1, 8'h03, 8'h05, lat);
    lit("sub35", 8'hFE, 1'b1, 1'b0);
    op(1'b1, 8'h80, 8'h01, lat);
    lit("sub80", 8'h7F, 1'b0, 1'b1);

    // start held high, operands scrambled while shifting
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    nd    = 0;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      if (done) nd++;
      a    = W'($urandom);
      b    = W'($urandom);
      mode = 1'($urandom);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("held_start_dones", W'(nd), W'(1));
    lit("held", 8'h33, 1'b0, 1'b0);

    // reset in the middle of a shift
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    a     = 8'h40;
    b     = 8'h40;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", W'(ready), W'(1));
    lit("mid_rst", 8'h00, 1'b0, 1'b0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_dones", W'(nd), W'(0));
    op(1'b0, 8'h01, 8'h01, lat);
    lit("add11", 8'h02, 1'b0, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
